// File: rtl/picomips_core.sv
// picomips_core: single-cycle parametrised picoMIPS with zero-flag branches and valid/ready I/O streams.
// Optional macro PICOMIPS_MUL_EN adds the one-cycle MUL instruction (opcode 11).
module picomips_core #(
  parameter int n     = 8,
  parameter int Psize = 6,
  parameter int NREG  = 8,
  localparam int R     = $clog2(NREG),
  localparam int Isize = 6 + 2 * R + n
) (
  input  logic             clk,
  input  logic             reset,
  output logic [Psize-1:0] prog_addr,
  input  logic [Isize-1:0] instr,
  input  logic [n-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [n-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             halted,
  output logic [1:0]       dbg_state
);

  // Stream handshakes: a word moves on either port only in a cycle where
  // valid && ready are both high at the rising edge; valid never waits on ready.
  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_STALL_IN  = 2'd1,
    S_STALL_OUT = 2'd2,
    S_HALTED    = 2'd3
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_ADDI = 6'd2;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd4;
  localparam logic [5:0] OP_IN   = 6'd5;
  localparam logic [5:0] OP_OUT  = 6'd6;
  localparam logic [5:0] OP_BEQ  = 6'd7;
  localparam logic [5:0] OP_BNE  = 6'd8;
  localparam logic [5:0] OP_JMP  = 6'd9;
  localparam logic [5:0] OP_HALT = 6'd10;
`ifdef PICOMIPS_MUL_EN
  localparam logic [5:0] OP_MUL  = 6'd11;
`endif

  state_t           state_q, state_d;
  logic [Psize-1:0] pc_q, pc_d;
  logic             z_q, z_d;
  logic [n-1:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [n-1:0]     rf_q [NREG];

  logic [5:0]       opcode;
  logic [R-1:0]     rd, rs;
  logic [n-1:0]     imm, rd_val, rs_val;
  logic [Psize-1:0] pc_inc, target;
  logic             alu_en;
  logic [n-1:0]     alu_res;
  logic             rf_we;
  logic [n-1:0]     rf_wdata;

  assign opcode = instr[Isize-1 -: 6];
  assign rd     = instr[Isize-7 -: R];
  assign rs     = instr[Isize-7-R -: R];
  assign imm    = instr[n-1:0];
  assign rd_val = (rd == '0) ? '0 : rf_q[rd];
  assign rs_val = (rs == '0) ? '0 : rf_q[rs];
  assign pc_inc = pc_q + 1'b1;
  assign target = Psize'(imm);

  always_comb begin
    alu_en  = 1'b1;
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = rd_val + rs_val;
      OP_ADDI: alu_res = rs_val + imm;
      OP_SUB:  alu_res = rd_val - rs_val;
      OP_AND:  alu_res = rd_val & rs_val;
`ifdef PICOMIPS_MUL_EN
      OP_MUL:  alu_res = rd_val * rs_val;
`endif
      default: alu_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    z_d         = z_q;
    rf_we       = 1'b0;
    rf_wdata    = '0;
    out_data_d  = out_data_q;
    // A pending word is retired whenever the consumer accepts it; a new OUT below may reload it.
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      S_RUN: begin
        if (alu_en) begin
          rf_we    = 1'b1;
          rf_wdata = alu_res;
          z_d      = (alu_res == '0);
          pc_d     = pc_inc;
        end else begin
          case (opcode)
            OP_IN: begin
              if (in_valid) begin
                rf_we    = 1'b1;
                rf_wdata = in_data;
                pc_d     = pc_inc;
              end else begin
                state_d = S_STALL_IN;
              end
            end
            OP_OUT: begin
              if (out_valid_q && !out_ready) begin
                state_d = S_STALL_OUT;
              end else begin
                out_data_d  = rs_val;
                out_valid_d = 1'b1;
                pc_d        = pc_inc;
              end
            end
            OP_BEQ:  pc_d = z_q ? target : pc_inc;
            OP_BNE:  pc_d = z_q ? pc_inc : target;
            OP_JMP:  pc_d = target;
            OP_HALT: state_d = S_HALTED;
            default: pc_d = pc_inc;
          endcase
        end
      end
      S_STALL_IN: begin
        if (in_valid) begin
          rf_we    = 1'b1;
          rf_wdata = in_data;
          pc_d     = pc_inc;
          state_d  = S_RUN;
        end
      end
      S_STALL_OUT: begin
        if (out_ready) begin
          out_data_d  = rs_val;
          out_valid_d = 1'b1;
          pc_d        = pc_inc;
          state_d     = S_RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      pc_q        <= '0;
      z_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      z_q         <= z_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Register file is deliberately unreset; r0 is never written and reads as zero.
  always_ff @(posedge clk) begin
    if (!reset && rf_we && (rd != '0)) begin
      rf_q[rd] <= rf_wdata;
    end
  end

  assign prog_addr = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = (state_q == S_HALTED);
  assign in_ready  = (opcode == OP_IN) && ((state_q == S_RUN) || (state_q == S_STALL_IN));
  assign dbg_state = state_q;

endmodule

// File: tb/tb_picomips_core.sv
// Directed bench for picomips_core: per-cycle vector table, halt/reset and wrap/MUL sequences.
module tb_picomips_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  prog_addr;
  logic [19:0] instr;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        halted;
  logic [1:0]  dbg_state;

  logic [19:0] rom [64];
  logic [7:0]  exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic [5:0] pc;
    logic       ov;
    logic [7:0] od;
    logic       ir;
    logic       h;
  } vec_t;

  vec_t tbl [20];

  picomips_core dut (
    .clk       (clk),
    .reset     (reset),
    .prog_addr (prog_addr),
    .instr     (instr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  assign instr = rom[prog_addr];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  function automatic logic [19:0] enc(input logic [5:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                              input logic [5:0] pc, input logic ov, input logic [7:0] od,
                              input logic ir, input logic h);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.pc = pc;
    v.ov = ov; v.od = od; v.ir = ir; v.h = h;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = enc(6'd0, 3'd0, 3'd0, 8'd0);
  endtask

  // Called at a negedge; returns at the negedge after reset is released.
  task automatic do_reset(input string tag);
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".pc"}, 32'(prog_addr), 32'd0);
    chk({tag, ".ov"}, 32'(out_valid), 32'd0);
    chk({tag, ".od"}, 32'(out_data), 32'd0);
    chk({tag, ".halted"}, 32'(halted), 32'd0);
    chk({tag, ".state"}, 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge: drive inputs, check pre-edge outputs, score a stream transfer.
  task automatic apply(input vec_t v, input string tag);
    logic [7:0] e;
    in_valid = v.iv; in_data = v.id; out_ready = v.ordy;
    #1;
    chk({tag, ".pc"}, 32'(prog_addr), 32'(v.pc));
    chk({tag, ".ov"}, 32'(out_valid), 32'(v.ov));
    chk({tag, ".od"}, 32'(out_data), 32'(v.od));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.ir));
    chk({tag, ".halted"}, 32'(halted), 32'(v.h));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".unexpected_out"}, 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk({tag, ".stream"}, 32'(out_data), 32'(e));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] mul_exp;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // Program 1: arithmetic, Z, branches, IN stall, OUT backpressure, HALT.
    clear_rom();
    rom[0]  = enc(6'd2,  3'd1, 3'd0, 8'd5);    // ADDI r1,r0,5
    rom[1]  = enc(6'd2,  3'd2, 3'd0, 8'd3);    // ADDI r2,r0,3
    rom[2]  = enc(6'd3,  3'd1, 3'd2, 8'd0);    // SUB r1,r2 -> 2
    rom[3]  = enc(6'd6,  3'd0, 3'd1, 8'd0);    // OUT r1
    rom[4]  = enc(6'd7,  3'd0, 3'd0, 8'd30);   // BEQ 30 (not taken)
    rom[5]  = enc(6'd3,  3'd1, 3'd1, 8'd0);    // SUB r1,r1 -> Z
    rom[6]  = enc(6'd7,  3'd0, 3'd0, 8'd20);   // BEQ 20 (taken)
    rom[20] = enc(6'd5,  3'd3, 3'd0, 8'd0);    // IN r3
    rom[21] = enc(6'd6,  3'd0, 3'd3, 8'd0);    // OUT r3
    rom[22] = enc(6'd6,  3'd0, 3'd2, 8'd0);    // OUT r2
    rom[23] = enc(6'd10, 3'd0, 3'd0, 8'd0);    // HALT

    //           iv    id     ordy  pc     ov    od     ir    h
    tbl[0]  = mk(1'b0, 8'h00, 1'b0, 6'd0,  1'b0, 8'h00, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 8'h00, 1'b0, 6'd1,  1'b0, 8'h00, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 8'h00, 1'b0, 6'd2,  1'b0, 8'h00, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 8'h00, 1'b0, 6'd3,  1'b0, 8'h00, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 8'h00, 1'b1, 6'd4,  1'b1, 8'h02, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 8'h00, 1'b0, 6'd5,  1'b0, 8'h02, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 8'h00, 1'b0, 6'd6,  1'b0, 8'h02, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 8'h00, 1'b0, 6'd20, 1'b0, 8'h02, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 8'h00, 1'b0, 6'd20, 1'b0, 8'h02, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 8'h00, 1'b0, 6'd20, 1'b0, 8'h02, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 8'h00, 1'b0, 6'd20, 1'b0, 8'h02, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 8'hA5, 1'b0, 6'd20, 1'b0, 8'h02, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 8'h00, 1'b0, 6'd21, 1'b0, 8'h02, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 8'h00, 1'b0, 6'd22, 1'b1, 8'hA5, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, 8'h00, 1'b0, 6'd22, 1'b1, 8'hA5, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 8'h00, 1'b1, 6'd22, 1'b1, 8'hA5, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 8'h00, 1'b0, 6'd23, 1'b1, 8'h03, 1'b0, 1'b0);
    tbl[17] = mk(1'b0, 8'h00, 1'b0, 6'd23, 1'b1, 8'h03, 1'b0, 1'b1);
    tbl[18] = mk(1'b0, 8'h00, 1'b1, 6'd23, 1'b1, 8'h03, 1'b0, 1'b1);
    tbl[19] = mk(1'b0, 8'h00, 1'b0, 6'd23, 1'b0, 8'h03, 1'b0, 1'b1);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h03);

    @(negedge clk);
    do_reset("reset1");
    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("p1[%0d]", i));

    // HALTED holds the PC until reset; a 1-cycle reset restarts at 0.
    for (int i = 0; i < 10; i++)
      apply(mk(1'b0, 8'h00, 1'b0, 6'd23, 1'b0, 8'h03, 1'b0, 1'b1), $sformatf("halt[%0d]", i));
    do_reset("reset_from_halt");

    // Program 2: overflow to zero, coincident OUT/out_ready, MUL, PC wrap 63->0.
    clear_rom();
    rom[0]  = enc(6'd2,  3'd4, 3'd0, 8'h77);   // ADDI r4,r0,0x77
    rom[1]  = enc(6'd6,  3'd0, 3'd4, 8'd0);    // OUT r4
    rom[2]  = enc(6'd2,  3'd1, 3'd0, 8'hFF);   // ADDI r1,r0,0xFF
    rom[3]  = enc(6'd2,  3'd1, 3'd1, 8'd1);    // ADDI r1,r1,1 -> 0, Z
    rom[4]  = enc(6'd6,  3'd0, 3'd1, 8'd0);    // OUT r1 (with out_ready)
    rom[5]  = enc(6'd7,  3'd0, 3'd0, 8'd60);   // BEQ 60
    rom[60] = enc(6'd2,  3'd1, 3'd0, 8'd12);   // ADDI r1,r0,12
    rom[61] = enc(6'd2,  3'd2, 3'd0, 8'd25);   // ADDI r2,r0,25
    rom[62] = enc(6'd11, 3'd1, 3'd2, 8'd0);    // MUL r1,r2
    rom[63] = enc(6'd6,  3'd0, 3'd1, 8'd0);    // OUT r1
`ifdef PICOMIPS_MUL_EN
    mul_exp = 8'h2C;
`else
    mul_exp = 8'h0C;
`endif
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h00);

    apply(mk(1'b0, 8'h00, 1'b0, 6'd0,  1'b0, 8'h00, 1'b0, 1'b0), "p2_addi");
    apply(mk(1'b0, 8'h00, 1'b0, 6'd1,  1'b0, 8'h00, 1'b0, 1'b0), "p2_out1");
    apply(mk(1'b0, 8'h00, 1'b0, 6'd2,  1'b1, 8'h77, 1'b0, 1'b0), "p2_ff");
    apply(mk(1'b0, 8'h00, 1'b0, 6'd3,  1'b1, 8'h77, 1'b0, 1'b0), "p2_wrapadd");
    apply(mk(1'b0, 8'h00, 1'b1, 6'd4,  1'b1, 8'h77, 1'b0, 1'b0), "p2_out_coincide");
    apply(mk(1'b0, 8'h00, 1'b0, 6'd5,  1'b1, 8'h00, 1'b0, 1'b0), "p2_beq_z");
    apply(mk(1'b0, 8'h00, 1'b0, 6'd60, 1'b1, 8'h00, 1'b0, 1'b0), "p2_target");
    apply(mk(1'b0, 8'h00, 1'b0, 6'd61, 1'b1, 8'h00, 1'b0, 1'b0), "p2_r2");
    apply(mk(1'b0, 8'h00, 1'b0, 6'd62, 1'b1, 8'h00, 1'b0, 1'b0), "p2_mul");
    apply(mk(1'b0, 8'h00, 1'b1, 6'd63, 1'b1, 8'h00, 1'b0, 1'b0), "p2_out_mul");
    apply(mk(1'b0, 8'h00, 1'b0, 6'd0,  1'b1, mul_exp, 1'b0, 1'b0), "p2_pc_wrap");

    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/picomips_core.md
# picomips_core

Parametrised successor to the picoMIPS CPU top level. It executes one instruction per cycle from an external combinational program memory, over a configurable data width and register count, with a zero-flag branch unit. Switch input and the LED output become valid/ready stream ports; the core stalls on backpressure instead of sampling or driving blindly. It sits between the program ROM and board I/O as the complete processor.

## Interface
- n, 8: data width (≥4)
- Psize, 6: program address width
- NREG, 8: number of general registers (power of 2, ≥2); R = log2(NREG)
- Isize, 6+2R+n: instruction width (derived, not overridden)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high master reset
- prog_addr  out  Psize  program counter, to program memory
- instr  in  Isize  instruction at prog_addr, combinational, same cycle
- in_data  in  n  input stream data (switches)
- in_valid  in  1  in_data valid
- in_ready  out  1  core is accepting in_data this cycle
- out_data  out  n  output stream data (LEDs), registered
- out_valid  out  1  out_data pending, registered
- out_ready  in  1  consumer accepts out_data
- halted  out  1  core in HALTED state

## Operation
- Instruction fields:
  - instr[Isize-1:Isize-6] is the opcode.
  - Next R bits are rd; next R bits are rs.
  - instr[n-1:0] is imm.
  - Branch target is imm[Psize-1:0].
- r0 reads 0; writes to r0 are discarded. Registers are not reset.
- Opcodes (arithmetic is modulo 2^n):
  - 0 NOP
  - 1 ADD: rd←rd+rs
  - 2 ADDI: rd←rs+imm
  - 3 SUB: rd←rd−rs
  - 4 AND: rd←rd&rs
  - 5 IN: rd←in_data
  - 6 OUT: out_data←rs
  - 7 BEQ: if Z, PC←target
  - 8 BNE: if !Z, PC←target
  - 9 JMP: PC←target
  - 10 HALT
  - 11 MUL (see Configuration)
  - All others behave as NOP.
- Z flag: registered. Updated only by ADD/ADDI/SUB/AND/MUL, set when the n-bit result is 0. Reset value 0.
- PC increment: PC+1 wraps from 2^Psize−1 to 0.
- FSM states:
  - RUN: normal execution.
    - IN with !in_valid → STALL_IN.
    - OUT with out_valid && !out_ready → STALL_OUT.
    - HALT → HALTED.
  - STALL_IN: PC held. in_ready=1. When in_valid: write rd, PC+1, → RUN.
  - STALL_OUT: PC held. When out_ready: load new out_data, PC+1, → RUN.
  - HALTED: PC held, no writes. Exit only via reset.
- in_ready=1 whenever the current instruction is IN in RUN or STALL_IN; a transfer is in_valid && in_ready.
- out_valid handshake:
  - OUT sets out_valid=1 with out_data=rs.
  - out_valid clears when out_ready is seen with no new OUT that cycle.
  - If OUT and out_ready coincide while out_valid=1, the old word is consumed, the new word is loaded, and out_valid stays 1. No stall.

## Timing
- Reset outputs:
  - prog_addr=0, out_data=0, out_valid=0, in_ready=0, halted=0.
  - Z=0, state RUN.
- Reset mid-stall or in HALTED returns to RUN at PC 0 on the next edge. A pending out_valid is dropped.
- Non-stalling instruction: 1 cycle; results visible to the next instruction (write at the edge, read combinationally).
- IN latency: 1 cycle if in_valid is already high, else 1 + the wait cycles.
- Branch taken: prog_addr=target on the cycle after the branch. No delay slot.
- out_data/out_valid change only at clock edges. in_ready is combinational from instr/state.

## Configuration
- PICOMIPS_MUL_EN defined: opcode 11 MUL computes rd←(rd×rs)[n-1:0] in one cycle and updates Z.
- Not defined: opcode 11 is NOP and no multiplier is synthesised.

## Test plan
- Reset then ADDI r1,r0,5; ADDI r2,r0,3; SUB r1,r2 → r1=2, Z=0. Then SUB r1,r1 → Z=1; BEQ to 20 → prog_addr=20 on the next cycle.
- IN r3 with in_valid low for 4 cycles → prog_addr held, in_ready=1 throughout. Raise in_valid with in_data=0xA5 → r3=0xA5 and PC advances once.
- Two back-to-back OUTs with out_ready=0 → first gives out_valid=1 and out_data=first value; second stalls. out_ready=1 for one cycle → second value loaded, out_valid stays 1.
- ADDI r1,r0,0xFF then ADDI r1,r1,1 (n=8) → r1=0, Z=1. PC wraps from 63 to 0 on a sequential instruction.
- HALT → halted=1 and prog_addr frozen for 10 cycles. Assert reset for 1 cycle → prog_addr=0, halted=0.
- With PICOMIPS_MUL_EN: r1=12, r2=25, MUL r1,r2 → r1=0x2C (300 mod 256). Without it: r1 stays 12.
